// File: rtl/hazard_scoreboard_p.sv
// hazard_scoreboard_p: decode-stage hazard detection and operand forwarding.
// A shifting scoreboard tracks the destination registers of instructions in
// the DEPTH post-decode stages (1 = E ... DEPTH = W). For each source operand
// the youngest matching producer is selected. The producer's result is either
// forwarded from its stage result bus, or decode is stalled because the
// producer is a load whose data is not yet available.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-low reset
//   id_valid         decode holds a valid instruction
//   id_rs/_used      NSRC source register numbers and per-operand read enables
//   id_rd/_wen       destination register and its write enable
//   id_is_load       decode instruction is a load
//   flush            kill the decode instruction (taken branch/jump)
//   rf_data          register-file read data, one XLEN slice per operand
//   stage_data       result bus of stage k at [(k-1)*XLEN +: XLEN]
//   stall            hold PC and IF/ID; a bubble enters EX
//   fwd_sel          per operand: 0 = register file, k = stage k
//   op_out           forwarded operand values
//   perf_stalls      saturating count of stall cycles
module hazard_scoreboard_p #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RADDR    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NSRC     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NSRC*RADDR-1:0]    id_rs,
  input  logic [NSRC-1:0]          id_rs_used,
  input  logic [RADDR-1:0]         id_rd,
  input  logic                     id_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [NSRC*XLEN-1:0]     rf_data,
  input  logic [DEPTH*XLEN-1:0]    stage_data,
  output logic                     stall,
  output logic [NSRC*$clog2(DEPTH+1)-1:0] fwd_sel,
  output logic [NSRC*XLEN-1:0]     op_out,
  output logic [31:0]              perf_stalls
);

  localparam int unsigned SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rd;
    logic             wen;
    logic             is_load;
  } sb_entry_t;

  sb_entry_t       sb_q [1:DEPTH];
  logic [NSRC-1:0] blocked;
  logic            issue;

  // Per-operand youngest-producer search and forwarding mux.
  for (genvar gi = 0; gi < int'(NSRC); gi++) begin : g_src
    logic [RADDR-1:0] rs;
    logic             hit;
    logic             rdy;
    logic [SELW-1:0]  win;
    logic [XLEN-1:0]  win_data;

    assign rs = id_rs[gi*RADDR +: RADDR];

    // Scan oldest to youngest so the lowest-k match overwrites older ones.
    always_comb begin
      hit      = 1'b0;
      rdy      = 1'b0;
      win      = '0;
      win_data = '0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (sb_q[k].valid && sb_q[k].wen && (sb_q[k].rd == rs) &&
            (rs != '0) && id_rs_used[gi]) begin
          hit      = 1'b1;
          win      = SELW'(k);
          rdy      = !sb_q[k].is_load || (k >= int'(LOAD_LAT));
          win_data = stage_data[(k-1)*int'(XLEN) +: XLEN];
        end
      end
    end

    assign blocked[gi]                 = hit & ~rdy;
    assign fwd_sel[gi*SELW +: SELW]    = (hit & rdy) ? win : '0;
    assign op_out[gi*XLEN +: XLEN]     = (hit & rdy) ? win_data
                                                     : rf_data[gi*XLEN +: XLEN];
  end

  // Flush overrides the hazard; an invalid decode slot never stalls.
  assign stall = id_valid & ~flush & (|blocked);
  assign issue = id_valid & ~stall & ~flush;

  // Scoreboard shift (never holds; stall or flush injects a bubble) and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        sb_q[k] <= '0;
      end
      perf_stalls <= '0;
    end else begin
      if (issue) begin
        sb_q[1] <= '{valid: 1'b1, rd: id_rd, wen: id_wen, is_load: id_is_load};
      end else begin
        sb_q[1] <= '0;
      end
      for (int k = 2; k <= int'(DEPTH); k++) begin
        sb_q[k] <= sb_q[k-1];
      end
      if (stall && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_p.sv
module tb_hazard_scoreboard_p;

  localparam logic [31:0] RF0 = 32'h0000_F000;
  localparam logic [31:0] RF1 = 32'h0000_F001;
  localparam logic [31:0] S1  = 32'h0000_AAAA;
  localparam logic [31:0] S2  = 32'h0000_BBBB;
  localparam logic [31:0] S3  = 32'h0000_CCCC;
  localparam logic [31:0] S4  = 32'h0000_DDDD;
  localparam logic [31:0] S5  = 32'h0000_EEEE;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_wen, id_is_load, flush;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [63:0] op_out;
  logic [31:0] perf_stalls;

  // DEPTH=5, LOAD_LAT=4 instance
  logic         b_id_valid;
  logic [9:0]   b_id_rs;
  logic [1:0]   b_id_rs_used;
  logic [4:0]   b_id_rd;
  logic         b_id_wen, b_id_is_load, b_flush;
  logic [63:0]  b_rf_data;
  logic [159:0] b_stage_data;
  logic         b_stall;
  logic [5:0]   b_fwd_sel;
  logic [63:0]  b_op_out;
  logic [31:0]  b_perf_stalls;

  hazard_scoreboard_p dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .rf_data(rf_data),
    .stage_data(stage_data), .stall(stall), .fwd_sel(fwd_sel),
    .op_out(op_out), .perf_stalls(perf_stalls)
  );

  hazard_scoreboard_p #(.DEPTH(5), .LOAD_LAT(4)) dut5 (
    .clk(clk), .reset(reset), .id_valid(b_id_valid), .id_rs(b_id_rs),
    .id_rs_used(b_id_rs_used), .id_rd(b_id_rd), .id_wen(b_id_wen),
    .id_is_load(b_id_is_load), .flush(b_flush), .rf_data(b_rf_data),
    .stage_data(b_stage_data), .stall(b_stall), .fwd_sel(b_fwd_sel),
    .op_out(b_op_out), .perf_stalls(b_perf_stalls)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but no queued expectation", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val && tag == e.tag)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h (queued %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [1:0] used, input logic [4:0] rd,
                     input logic wen, input logic ld, input logic fl);
    id_valid   = v;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_wen     = wen;
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic b_drv(input logic v, input logic [4:0] rs0, input logic [1:0] used,
                       input logic [4:0] rd, input logic wen, input logic ld);
    b_id_valid   = v;
    b_id_rs      = {5'd0, rs0};
    b_id_rs_used = used;
    b_id_rd      = rd;
    b_id_wen     = wen;
    b_id_is_load = ld;
    b_flush      = 1'b0;
  endtask

  // Combinational outputs of the default instance; c0=0 skips a don't-care op0.
  task automatic check_main(input logic es, input logic [1:0] s0, input bit c0,
                            input logic [31:0] o0, input logic [1:0] s1,
                            input logic [31:0] o1);
    push("stall", 64'(es));
    push("sel0", 64'(s0));
    if (c0) push("op0", 64'(o0));
    push("sel1", 64'(s1));
    push("op1", 64'(o1));
    #1;
    pop_chk("stall", 64'(stall));
    pop_chk("sel0", 64'(fwd_sel[1:0]));
    if (c0) pop_chk("op0", 64'(op_out[31:0]));
    pop_chk("sel1", 64'(fwd_sel[3:2]));
    pop_chk("op1", 64'(op_out[63:32]));
  endtask

  task automatic check5(input logic es, input logic [2:0] s0, input bit c0,
                        input logic [31:0] o0);
    push("b_stall", 64'(es));
    push("b_sel0", 64'(s0));
    if (c0) push("b_op0", 64'(o0));
    #1;
    pop_chk("b_stall", 64'(b_stall));
    pop_chk("b_sel0", 64'(b_fwd_sel[2:0]));
    if (c0) pop_chk("b_op0", 64'(b_op_out[31:0]));
  endtask

  task automatic check_perf(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
    push(tag, 64'(expv));
    pop_chk(tag, 64'(obs));
  endtask

  initial begin
    reset        = 1'b0;
    rf_data      = {RF1, RF0};
    stage_data   = {S3, S2, S1};
    b_rf_data    = {RF1, RF0};
    b_stage_data = {S5, S4, S3, S2, S1};
    drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    b_drv(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Reset state
    #2;
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    check_perf("perf_rst", perf_stalls, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ALU back-to-back: add r3, then read r3
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b0, 2'd1, 1'b1, S1, 2'd0, RF1);

    // Load-use: lw r4 then consumer -> exactly one stall cycle
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b1, 2'd0, 1'b0, 32'd0, 2'd0, RF1);
    check_perf("perf_pre", perf_stalls, 32'd0);
    @(negedge clk);
    check_main(1'b0, 2'd2, 1'b1, S2, 2'd0, RF1);
    check_perf("perf_lu", perf_stalls, 32'd1);

    // Youngest priority: r7 in stages 1 and 3
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
    check_main(1'b0, 2'd1, 1'b1, S1, 2'd1, S1);

    // r0 in flight is never forwarded; this instruction is lw r5
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd9, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    // Unused operands matching a pending load do not stall
    @(negedge clk);
    drv(1'b1, 5'd5, 5'd5, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);

    // Flush during load-use hazard: no stall, bubble, counter unchanged
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd6, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b1);
    check_main(1'b0, 2'd0, 1'b0, 32'd0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b0, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b0, 2'd2, 1'b1, S2, 2'd0, RF1);
    check_perf("perf_flush", perf_stalls, 32'd1);

    // id_valid=0 with an unready load match: no stall
    @(negedge clk);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b0, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b0, 2'd0, 1'b0, 32'd0, 2'd0, RF1);

    // DEPTH=5, LOAD_LAT=4: load then consumer -> 3 stalls, then stage 4
    @(negedge clk);
    drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    b_drv(1'b1, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
    check5(1'b0, 3'd0, 1'b1, RF0);
    @(negedge clk);
    b_drv(1'b1, 5'd4, 2'b01, 5'd0, 1'b0, 1'b0);
    check5(1'b1, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    check5(1'b1, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    check5(1'b1, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    check5(1'b0, 3'd4, 1'b1, S4);
    check_perf("b_perf", b_perf_stalls, 32'd3);
    check_perf("perf_idle", perf_stalls, 32'd1);

    // Reset asserted mid-stall drops the stall immediately
    @(negedge clk);
    b_drv(1'b0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check_main(1'b1, 2'd0, 1'b0, 32'd0, 2'd0, RF1);
    #1;
    reset = 1'b0;
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    check_perf("perf_async", perf_stalls, 32'd0);
    check_perf("b_perf_async", b_perf_stalls, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    @(negedge clk);
    check_main(1'b0, 2'd0, 1'b1, RF0, 2'd0, RF1);
    check_perf("perf_post", perf_stalls, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_p.md
Name: hazard_scoreboard_p

Overview:
- Parametrised successor to the decode-stage hazard/forwarding logic.
- Tracks in-flight destination registers across DEPTH pipeline stages after decode, in a shifting scoreboard.
- Per source operand: selects the youngest ready producer (or the register file), drives the forwarded operand, and stalls decode while a load result is not yet available.
- Sits between the register-file read and the ID/EX pipeline register; also counts stall cycles.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 3, tracked post-decode stages (1=E ... DEPTH=W); legal 2..8.
- LOAD_LAT, 2, first stage index at which a load result can be forwarded; legal 1..DEPTH.
- NSRC, 2, source operands per instruction; legal 1..3.
- Derived, not overridable: SELW = clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs  in  NSRC*RADDR  source register numbers; operand i at [i*RADDR +: RADDR].
- id_rs_used  in  NSRC  operand i is actually read.
- id_rd  in  RADDR  destination register.
- id_wen  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill the decode instruction (taken branch/jump).
- rf_data  in  NSRC*XLEN  register-file read data per operand.
- stage_data  in  DEPTH*XLEN  result bus of stage k at [(k-1)*XLEN +: XLEN].
- stall  out  1  hold PC and IF/ID; bubble into EX.
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = stage k.
- op_out  in/out: out  NSRC*XLEN  forwarded operand values.
- perf_stalls  out  32  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, reset=0): all scoreboard entries invalid, perf_stalls=0. While reset is held, stall=0 and fwd_sel=0, so op_out=rf_data. Reset mid-stall drops the stall immediately.
- Scoreboard entry k (1..DEPTH) holds: valid, rd, wen, is_load.
- Issue: issue = id_valid & ~stall & ~flush.
- Every clock edge:
  - entry[1] <= issue ? {1, id_rd, id_wen, id_is_load} : bubble (valid=0).
  - entry[k+1] <= entry[k] for k < DEPTH.
  - entry[DEPTH] retires.
  - The scoreboard never holds; a stall injects a bubble.
- Match rule for operand i against entry k: valid & wen & (rd == rs_i) & (rs_i != 0) & id_rs_used[i].
- Readiness: entry k is ready iff ~is_load or k >= LOAD_LAT.
- Priority: the lowest-k (youngest) matching entry wins; older matches are ignored.
- Forwarding:
  - Winning entry ready: fwd_sel_i = k, op_out_i = stage_data[k].
  - No match: fwd_sel_i = 0, op_out_i = rf_data_i.
  - Winning entry not ready: fwd_sel_i = 0; the value is don't-care.
- A match in stage DEPTH (writeback) is forwarded: write-through, no same-cycle register-file bypass is assumed.
- stall = id_valid & ~flush & (any operand's winning entry not ready). Purely combinational from inputs and the current scoreboard.
- Stall duration: a load at entry k stalls decode for LOAD_LAT-k cycles; a back-to-back load-use with LOAD_LAT=2 stalls exactly 1 cycle.
- flush has priority over stall: stall=0, bubble inserted, no counter increment.
- perf_stalls increments on each cycle with stall=1 and holds at 0xFFFFFFFF.
- id_valid=0 gives stall=0; fwd_sel is still computed.

Test Plan:
- Reset: drive reset=0 mid-stall (load r5 in E, consumer reads r5) -> stall falls to 0 asynchronously; after release, scoreboard is empty, fwd_sel=0, perf_stalls=0.
- ALU back-to-back (defaults): issue add r3 (no load), then an instruction reading r3 with stage_data[1]=0x1234 -> fwd_sel=1, op_out=0x1234, stall=0.
- Load-use (LOAD_LAT=2): issue lw r4, then a consumer of r4 -> stall=1 for one cycle; next cycle fwd_sel=2, op_out=stage_data[2]; perf_stalls=1.
- Youngest priority: r7 written in stages 1 and 3, stage_data 0xAAAA/0xCCCC -> fwd_sel=1, op_out=0xAAAA.
- r0 and unused operand: rs=0 with r0 in flight -> fwd_sel=0, op_out=rf_data. id_rs_used=0 with a pending load match -> no stall.
- Flush during load-use hazard -> stall=0, entry[1] bubble, perf_stalls unchanged.
- Parameter sweep DEPTH=5, LOAD_LAT=4: load followed by consumer -> 3 stall cycles, then fwd_sel=4.
